// File: rtl/team_06_echo_pkg.sv
// Shared constants, FSM encoding and address helper for the echo delay buffer.
package team_06_echo_pkg;

    localparam int ECHO_DEPTH  = 8192;
    localparam int ECHO_ADDR_W = 13;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECIDE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_WR_WAIT
    } echo_buf_state_t;

    function automatic logic [31:0] ring_addr(input logic [31:0] base,
                                              input logic [ECHO_ADDR_W-1:0] idx);
        return base + {{(32-ECHO_ADDR_W){1'b0}}, idx};
    endfunction

endpackage

// File: rtl/team_06_ring_ptr.sv
// Ring write pointer, saturating fill counter and read-index subtraction.
module team_06_ring_ptr #(
    parameter int DEPTH  = 8192,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              advance,
    input  logic [ADDR_W-1:0] offset,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W-1:0] fill,
    output logic [ADDR_W-1:0] rd_idx
);

    localparam logic [ADDR_W-1:0] FILL_MAX = ADDR_W'(DEPTH - 1);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            fill   <= '0;
        end else if (advance) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (fill != FILL_MAX) begin
                fill <= fill + 1'b1;
            end
        end
    end

    // Modulo-DEPTH wrap falls out of the ADDR_W-bit subtraction.
    assign rd_idx = wr_ptr - offset;

endmodule

// File: rtl/team_06_echo_delay_buffer.sv
// SRAM-side ring buffer responder: stores each sample and optionally returns one from 'offset' samples ago.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no transaction; takes the pending sample when one is waiting
// ST_DECIDE  | resolve search: immediate answer or SRAM read
// ST_RD_REQ  | first cycle of the past-sample read
// ST_RD_WAIT | read held until mem_ack
// ST_WR_REQ  | first cycle of the sample write
// ST_WR_WAIT | write held until mem_ack, then pointer advances
module team_06_echo_delay_buffer
    import team_06_echo_pkg::*;
#(
    parameter int          DEPTH     = ECHO_DEPTH,
    parameter int          ADDR_W    = ECHO_ADDR_W,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              sample_valid,
    input  logic [7:0]        save_audio,
    input  logic              search,
    input  logic [ADDR_W-1:0] offset,
    output logic [7:0]        past_output,
    output logic              past_valid,
    output logic              busy,
    output logic              overflow,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack
);

    echo_buf_state_t   state;

    logic              slot_full;
    logic [7:0]        slot_sample;
    logic              slot_search;
    logic [ADDR_W-1:0] slot_offset;

    logic [7:0]        cur_sample;
    logic              cur_search;
    logic [ADDR_W-1:0] cur_offset;

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] fill;
    logic [ADDR_W-1:0] rd_idx;

    logic              take;
    logic              advance;
    logic              do_read;

    assign take    = (state == ST_IDLE) && slot_full;
    assign advance = ((state == ST_WR_REQ) || (state == ST_WR_WAIT)) && mem_ack;
    assign do_read = cur_search && (cur_offset != '0) && (cur_offset <= fill);
    assign busy    = (state != ST_IDLE);

    team_06_ring_ptr #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ring_ptr (
        .clk     (clk),
        .nrst    (nrst),
        .advance (advance),
        .offset  (cur_offset),
        .wr_ptr  (wr_ptr),
        .fill    (fill),
        .rd_idx  (rd_idx)
    );

    // The slot is emptied the cycle the FSM copies it, so a strobe in that cycle still lands.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            slot_full   <= 1'b0;
            slot_sample <= '0;
            slot_search <= 1'b0;
            slot_offset <= '0;
            overflow    <= 1'b0;
        end else if (sample_valid && (!slot_full || take)) begin
            slot_full   <= 1'b1;
            slot_sample <= save_audio;
            slot_search <= search;
            slot_offset <= offset;
        end else if (take) begin
            slot_full <= 1'b0;
        end else if (sample_valid) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= ST_IDLE;
            cur_sample  <= '0;
            cur_search  <= 1'b0;
            cur_offset  <= '0;
            past_output <= '0;
            past_valid  <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            past_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (slot_full) begin
                        cur_sample <= slot_sample;
                        cur_search <= slot_search;
                        cur_offset <= slot_offset;
                        state      <= ST_DECIDE;
                    end
                end
                ST_DECIDE: begin
                    if (cur_search && (cur_offset == '0)) begin
                        past_output <= cur_sample;
                        past_valid  <= 1'b1;
                    end else if (cur_search && (cur_offset > fill)) begin
                        past_output <= '0;
                        past_valid  <= 1'b1;
                    end
                    mem_req <= 1'b1;
                    if (do_read) begin
                        state    <= ST_RD_REQ;
                        mem_we   <= 1'b0;
                        mem_addr <= ring_addr(BASE_ADDR, rd_idx);
                    end else begin
                        state     <= ST_WR_REQ;
                        mem_we    <= 1'b1;
                        mem_addr  <= ring_addr(BASE_ADDR, wr_ptr);
                        mem_wdata <= cur_sample;
                    end
                end
                ST_RD_REQ, ST_RD_WAIT: begin
                    if (mem_ack) begin
                        past_output <= mem_rdata;
                        past_valid  <= 1'b1;
                        state       <= ST_WR_REQ;
                        mem_we      <= 1'b1;
                        mem_addr    <= ring_addr(BASE_ADDR, wr_ptr);
                        mem_wdata   <= cur_sample;
                    end else begin
                        state <= ST_RD_WAIT;
                    end
                end
                ST_WR_REQ, ST_WR_WAIT: begin
                    if (mem_ack) begin
                        state   <= ST_IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end else begin
                        state <= ST_WR_WAIT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_team_06_echo_delay_buffer.sv
// Directed bench for the echo delay buffer with a behavioural SRAM responder.
module tb_team_06_echo_delay_buffer;

    localparam int DEPTH  = 8192;
    localparam int ADDR_W = 13;

    logic              clk;
    logic              nrst;
    logic              sample_valid;
    logic [7:0]        save_audio;
    logic              search;
    logic [ADDR_W-1:0] offset;
    logic [7:0]        past_output;
    logic              past_valid;
    logic              busy;
    logic              overflow;
    logic              mem_req;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              mem_ack;

    int checks = 0;
    int errors = 0;
    int lat = 1;

    logic [7:0] mem_model [DEPTH];
    int         ack_cnt;
    int         wlog_a[$];
    int         wlog_d[$];
    int         rlog_a[$];

    int         cyc = 0;
    int         sv_cyc = 0;
    int         pv_cyc = 0;
    int         idle_cyc = 0;
    int         pv_cnt = 0;
    logic [7:0] last_past = 8'h00;
    logic       busy_q = 1'b0;

    team_06_echo_delay_buffer #(
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (32'h0)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .sample_valid (sample_valid),
        .save_audio   (save_audio),
        .search       (search),
        .offset       (offset),
        .past_output  (past_output),
        .past_valid   (past_valid),
        .busy         (busy),
        .overflow     (overflow),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: acks 'lat' cycles after it first sees a request, one pulse per access.
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mem_ack   <= 1'b0;
            mem_rdata <= 8'h00;
            ack_cnt   <= 0;
        end else begin
            mem_ack <= 1'b0;
            if (mem_req && !mem_ack) begin
                if (ack_cnt >= lat - 1) begin
                    mem_ack <= 1'b1;
                    ack_cnt <= 0;
                    if (mem_we) begin
                        mem_model[mem_addr[ADDR_W-1:0]] <= mem_wdata;
                        wlog_a.push_back(int'(mem_addr));
                        wlog_d.push_back(int'(mem_wdata));
                    end else begin
                        mem_rdata <= mem_model[mem_addr[ADDR_W-1:0]];
                        rlog_a.push_back(int'(mem_addr));
                    end
                end else begin
                    ack_cnt <= ack_cnt + 1;
                end
            end else begin
                ack_cnt <= 0;
            end
        end
    end

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        busy_q <= busy;
        if (sample_valid) sv_cyc <= cyc;
        if (past_valid) begin
            pv_cnt    <= pv_cnt + 1;
            pv_cyc    <= cyc;
            last_past <= past_output;
        end
        if (busy_q && !busy) idle_cyc <= cyc;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!busy && n < 8) begin
            @(negedge clk);
            n++;
        end
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout observed=busy expected=idle", tag);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] s, input logic srch, input logic [ADDR_W-1:0] off);
        sample_valid = 1'b1;
        save_audio   = s;
        search       = srch;
        offset       = off;
        @(negedge clk);
        sample_valid = 1'b0;
        search       = 1'b0;
        wait_idle("send");
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int w0, r0, p0, n;
        sample_valid = 1'b0;
        save_audio   = 8'h00;
        search       = 1'b0;
        offset       = '0;
        nrst         = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_past_output", {24'h0, past_output}, 32'h0);
        check("rst_past_valid",  {31'h0, past_valid},  32'h0);
        check("rst_busy",        {31'h0, busy},        32'h0);
        check("rst_overflow",    {31'h0, overflow},    32'h0);
        check("rst_mem_req",     {31'h0, mem_req},     32'h0);
        check("rst_mem_addr",    mem_addr,             32'h0);
        nrst = 1'b1;
        @(negedge clk);

        // Three plain writes land in consecutive ring slots, no fetches.
        lat = 1;
        w0 = wlog_a.size();
        p0 = pv_cnt;
        send(8'h10, 1'b0, 13'd0);
        send(8'h20, 1'b0, 13'd0);
        send(8'h30, 1'b0, 13'd0);
        check("t1_write_count", wlog_a.size() - w0, 3);
        check("t1_addr0", wlog_a[w0],   32'd0);
        check("t1_addr1", wlog_a[w0+1], 32'd1);
        check("t1_addr2", wlog_a[w0+2], 32'd2);
        check("t1_data2", wlog_d[w0+2], 32'h30);
        check("t1_no_past_valid", pv_cnt - p0, 0);

        // wr_ptr=3: offset 2 reads slot 1, then the new sample goes to slot 3.
        w0 = wlog_a.size();
        r0 = rlog_a.size();
        p0 = pv_cnt;
        send(8'h40, 1'b1, 13'd2);
        check("t2_read_count", rlog_a.size() - r0, 1);
        check("t2_read_addr",  rlog_a[r0], 32'd1);
        check("t2_past",       {24'h0, last_past}, 32'h20);
        check("t2_past_held",  {24'h0, past_output}, 32'h20);
        check("t2_pv_pulses",  pv_cnt - p0, 1);
        check("t2_write_addr", wlog_a[w0], 32'd3);
        check("t2_write_data", wlog_d[w0], 32'h40);
        // Counters are sampled the edge after the output changes, hence the -1.
        check("t2_pv_latency",   pv_cyc - sv_cyc - 1, 4);
        check("t2_idle_latency", idle_cyc - sv_cyc - 1, 6);

        // Empty buffer: offset beyond fill answers 0 without touching SRAM.
        do_reset();
        w0 = wlog_a.size();
        r0 = rlog_a.size();
        p0 = pv_cnt;
        send(8'h55, 1'b1, 13'd5);
        check("t3_past",       {24'h0, last_past}, 32'h00);
        check("t3_pv_pulses",  pv_cnt - p0, 1);
        check("t3_no_read",    rlog_a.size() - r0, 0);
        check("t3_write_addr", wlog_a[w0], 32'd0);
        check("t3_write_data", wlog_d[w0], 32'h55);

        // Wrap: after DEPTH+2 writes wr_ptr=2, so offset DEPTH-1 reads slot 3 (value 3).
        do_reset();
        for (int i = 0; i < DEPTH + 2; i++) begin
            send(8'(i), 1'b0, 13'd0);
        end
        w0 = wlog_a.size();
        r0 = rlog_a.size();
        send(8'h02, 1'b1, 13'(DEPTH - 1));
        check("t4_read_count", rlog_a.size() - r0, 1);
        check("t4_read_addr",  rlog_a[r0], 32'd3);
        check("t4_past",       {24'h0, last_past}, 32'h03);
        check("t4_write_addr", wlog_a[w0], 32'd2);

        // Slow SRAM, back-to-back strobes: first runs, second waits, third dropped.
        do_reset();
        check("t5_overflow_clear", {31'h0, overflow}, 32'h0);
        lat = 5;
        w0 = wlog_a.size();
        sample_valid = 1'b1;
        search       = 1'b0;
        offset       = '0;
        save_audio   = 8'hA1;
        @(negedge clk);
        save_audio   = 8'hA2;
        @(negedge clk);
        save_audio   = 8'hA3;
        @(negedge clk);
        sample_valid = 1'b0;
        n = 0;
        while (((wlog_a.size() - w0) < 2 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        check("t5_overflow",    {31'h0, overflow}, 32'h1);
        check("t5_write_count", wlog_a.size() - w0, 2);
        check("t5_data0",       wlog_d[w0],   32'hA1);
        check("t5_data1",       wlog_d[w0+1], 32'hA2);
        check("t5_addr1",       wlog_a[w0+1], 32'd1);

        // Reset while a read is outstanding.
        do_reset();
        lat = 1;
        send(8'h11, 1'b0, 13'd0);
        send(8'h22, 1'b0, 13'd0);
        lat = 5;
        sample_valid = 1'b1;
        save_audio   = 8'h33;
        search       = 1'b1;
        offset       = 13'd1;
        @(negedge clk);
        sample_valid = 1'b0;
        search       = 1'b0;
        n = 0;
        while (!(mem_req && !mem_we) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t6_read_started", {30'h0, mem_req, mem_we}, 32'h2);
        repeat (2) @(negedge clk);
        nrst = 1'b0;
        #1;
        check("t6_req_async_drop", {31'h0, mem_req}, 32'h0);
        check("t6_busy_cleared",   {31'h0, busy},    32'h0);
        @(negedge clk);
        nrst = 1'b1;
        lat  = 1;
        @(negedge clk);
        w0 = wlog_a.size();
        r0 = rlog_a.size();
        send(8'h77, 1'b1, 13'd1);
        check("t6_past_after_rst", {24'h0, last_past}, 32'h00);
        check("t6_no_read",        rlog_a.size() - r0, 0);
        check("t6_write_addr",     wlog_a[w0], 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
